// File: rtl/price_channel_scheduler.sv
// Round-robin scheduler sharing one hysteresis/debounce threshold engine
// across N_CH price feeds, with runtime threshold reconfiguration.
module price_channel_scheduler #(
   parameter int N_CH             = 4,
   parameter int PRICE_W          = 8,
   parameter int UPPER_INIT       = 105,
   parameter int LOWER_INIT       = 95,
   parameter int DEBOUNCE_SAMPLES = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CH-1:0]           i_req_valid,
   input  logic [N_CH*PRICE_W-1:0]   i_req_price,
   output logic [N_CH-1:0]           o_req_ready,
   input  logic                      i_cfg_valid,
   input  logic [PRICE_W-1:0]        i_cfg_upper,
   input  logic [PRICE_W-1:0]        i_cfg_lower,
   output logic                      o_cfg_ready,
   output logic                      o_cfg_err,
   output logic                      o_res_valid,
   output logic [$clog2(N_CH)-1:0]   o_res_ch,
   output logic [1:0]                o_res_code,
   output logic                      o_res_changed,
   output logic [N_CH*2-1:0]         o_ch_code
);

   localparam int CH_W  = $clog2(N_CH);
   localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

   typedef enum logic [1:0] {
      P_NONE = 2'b00,
      P_RISE = 2'b01,
      P_FALL = 2'b10
   } pend_t;

   localparam logic [1:0] C_IDLE = 2'b00;
   localparam logic [1:0] C_BAND = 2'b01;
   localparam logic [1:0] C_HIGH = 2'b11;
   localparam logic [1:0] C_LOW  = 2'b10;

   logic [PRICE_W-1:0] r_upper;
   logic [PRICE_W-1:0] r_lower;
   logic [CH_W-1:0]    r_rr_ptr;
   logic [1:0]         r_code [N_CH];
   pend_t              r_pend [N_CH];
   logic [CNT_W-1:0]   r_cnt  [N_CH];

   logic               r_cfg_err;
   logic               r_res_valid;
   logic [CH_W-1:0]    r_res_ch;
   logic [1:0]         r_res_code;
   logic               r_res_changed;

   logic               w_any;
   logic [CH_W-1:0]    w_gidx;
   logic [N_CH-1:0]    w_grant;
   logic [PRICE_W-1:0] w_price;
   logic               w_above;
   logic               w_below;
   logic [1:0]         w_old_code;
   logic [1:0]         w_ncode;
   pend_t              w_npend;
   logic [CNT_W-1:0]   w_ncnt;

   // Search from rr_ptr upward with wrap; config and reset block all grants.
   always_comb begin
      w_any   = 1'b0;
      w_gidx  = '0;
      w_grant = '0;
      for (int k = 0; k < N_CH; k++) begin
         int j;
         j = int'(r_rr_ptr) + k;
         if (j >= N_CH) j = j - N_CH;
         if (!w_any && i_req_valid[j]) begin
            w_any  = 1'b1;
            w_gidx = CH_W'(j);
         end
      end
      if (reset || i_cfg_valid) w_any = 1'b0;
      if (w_any) w_grant[w_gidx] = 1'b1;
   end

   assign o_req_ready = w_grant;
   assign w_price     = i_req_price[w_gidx*PRICE_W +: PRICE_W];
   assign w_above     = (w_price >= r_upper);
   assign w_below     = (w_price <= r_lower);
   assign w_old_code  = r_code[w_gidx];

   always_comb begin
      w_ncode = w_old_code;
      w_npend = r_pend[w_gidx];
      w_ncnt  = r_cnt[w_gidx];
      if (w_above) begin
         if (w_old_code != C_HIGH) begin
            if (r_pend[w_gidx] == P_RISE) begin
               w_ncnt = r_cnt[w_gidx] + 1'b1;
            end else begin
               w_npend = P_RISE;
               w_ncnt  = CNT_W'(1);
            end
            if (w_ncnt == CNT_W'(DEBOUNCE_SAMPLES)) begin
               w_ncode = C_HIGH;
               w_npend = P_NONE;
               w_ncnt  = '0;
            end
         end
      end else if (w_below) begin
         if (w_old_code != C_LOW) begin
            if (r_pend[w_gidx] == P_FALL) begin
               w_ncnt = r_cnt[w_gidx] + 1'b1;
            end else begin
               w_npend = P_FALL;
               w_ncnt  = CNT_W'(1);
            end
            if (w_ncnt == CNT_W'(DEBOUNCE_SAMPLES)) begin
               w_ncode = C_LOW;
               w_npend = P_NONE;
               w_ncnt  = '0;
            end
         end
      end else begin
         w_ncode = C_BAND;
         w_npend = P_NONE;
         w_ncnt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_upper       <= PRICE_W'(UPPER_INIT);
         r_lower       <= PRICE_W'(LOWER_INIT);
         r_rr_ptr      <= '0;
         r_cfg_err     <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_ch      <= '0;
         r_res_code    <= C_IDLE;
         r_res_changed <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_code[i] <= C_IDLE;
            r_pend[i] <= P_NONE;
            r_cnt[i]  <= '0;
         end
      end else begin
         r_cfg_err   <= 1'b0;
         r_res_valid <= 1'b0;
         if (i_cfg_valid) begin
            if (i_cfg_upper >= i_cfg_lower) begin
               r_upper <= i_cfg_upper;
               r_lower <= i_cfg_lower;
               for (int i = 0; i < N_CH; i++) begin
                  r_code[i] <= C_IDLE;
                  r_pend[i] <= P_NONE;
                  r_cnt[i]  <= '0;
               end
            end else begin
               r_cfg_err <= 1'b1;
            end
         end else if (w_any) begin
            r_code[w_gidx] <= w_ncode;
            r_pend[w_gidx] <= w_npend;
            r_cnt[w_gidx]  <= w_ncnt;
            r_rr_ptr       <= (w_gidx == CH_W'(N_CH - 1)) ? '0 : w_gidx + 1'b1;
            r_res_valid    <= 1'b1;
            r_res_ch       <= w_gidx;
            r_res_code     <= w_ncode;
            r_res_changed  <= (w_ncode != w_old_code);
         end
      end
   end

   always_comb begin
      o_ch_code = '0;
      for (int i = 0; i < N_CH; i++) begin
         o_ch_code[i*2 +: 2] = r_code[i];
      end
   end

   assign o_cfg_ready   = 1'b1;
   assign o_cfg_err     = r_cfg_err;
   assign o_res_valid   = r_res_valid;
   assign o_res_ch      = r_res_ch;
   assign o_res_code    = r_res_code;
   assign o_res_changed = r_res_changed;

endmodule

// File: tb/tb_price_channel_scheduler.sv
// Directed bench for price_channel_scheduler with hand-computed expectations.
module tb_price_channel_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_price = '0;
   logic [3:0]  req_ready;
   logic        cfg_valid = 1'b0;
   logic [7:0]  cfg_upper = '0;
   logic [7:0]  cfg_lower = '0;
   logic        cfg_ready;
   logic        cfg_err;
   logic        res_valid;
   logic [1:0]  res_ch;
   logic [1:0]  res_code;
   logic        res_changed;
   logic [7:0]  ch_code;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   price_channel_scheduler #(
      .N_CH(4), .PRICE_W(8), .UPPER_INIT(105),
      .LOWER_INIT(95), .DEBOUNCE_SAMPLES(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_req_valid(req_valid),
      .i_req_price(req_price),
      .o_req_ready(req_ready),
      .i_cfg_valid(cfg_valid),
      .i_cfg_upper(cfg_upper),
      .i_cfg_lower(cfg_lower),
      .o_cfg_ready(cfg_ready),
      .o_cfg_err(cfg_err),
      .o_res_valid(res_valid),
      .o_res_ch(res_ch),
      .o_res_code(res_code),
      .o_res_changed(res_changed),
      .o_ch_code(ch_code)
   );

   task automatic send(input int ch, input logic [7:0] p);
      req_valid = '0;
      req_valid[ch] = 1'b1;
      req_price[ch*8 +: 8] = p;
      @(posedge clk); #2;
      req_valid = '0;
   endtask

   task automatic do_cfg(input logic [7:0] u, input logic [7:0] l);
      cfg_valid = 1'b1;
      cfg_upper = u;
      cfg_lower = l;
      @(posedge clk); #2;
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 4'hF;
      #1;
      vecs++;
      if (req_ready !== 4'b0000) begin
         errs++;
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      repeat (2) @(posedge clk);
      #2;
      vecs++;
      if (res_valid !== 1'b0 || res_ch !== 2'd0 || res_code !== 2'b00 ||
          res_changed !== 1'b0 || cfg_err !== 1'b0 || ch_code !== 8'h00) begin
         errs++;
         $display("FAIL reset_outs: got v=%b ch=%0d code=%b chg=%b err=%b cc=%h want all 0",
                  res_valid, res_ch, res_code, res_changed, cfg_err, ch_code);
      end
      vecs++;
      if (cfg_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
      end
      reset = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_fairness;
      req_valid = 4'hF;
      req_price = {8'd100, 8'd100, 8'd100, 8'd100};
      for (int k = 0; k < 8; k++) begin
         #1;
         vecs++;
         if (req_ready !== 4'(1 << (k % 4))) begin
            errs++;
            $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
         end
         @(posedge clk); #2;
         vecs++;
         if (res_valid !== 1'b1 || res_ch !== 2'(k % 4) || res_code !== 2'b01 ||
             res_changed !== (k < 4)) begin
            errs++;
            $display("FAIL fair_res[%0d]: got v=%b ch=%0d code=%b chg=%b want v=1 ch=%0d code=01 chg=%b",
                     k, res_valid, res_ch, res_code, res_changed, k % 4, k < 4);
         end
      end
      req_valid = '0;
      @(posedge clk); #2;
      vecs++;
      if (res_valid !== 1'b0 || ch_code !== 8'h55) begin
         errs++;
         $display("FAIL fair_idle: got v=%b cc=%h want v=0 cc=55", res_valid, ch_code);
      end
   endtask

   task automatic test_debounce;
      logic [7:0] pr [4];
      logic [1:0] ec [4];
      logic       eg [4];
      pr = '{8'd110, 8'd110, 8'd110, 8'd110};
      ec = '{2'b00, 2'b00, 2'b11, 2'b11};
      eg = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_cfg(8'd105, 8'd95);
      for (int k = 0; k < 4; k++) begin
         send(2, pr[k]);
         vecs++;
         if (res_valid !== 1'b1 || res_ch !== 2'd2 || res_code !== ec[k] ||
             res_changed !== eg[k]) begin
            errs++;
            $display("FAIL debounce[%0d]: got v=%b ch=%0d code=%b chg=%b want v=1 ch=2 code=%b chg=%b",
                     k, res_valid, res_ch, res_code, res_changed, ec[k], eg[k]);
         end
      end
      vecs++;
      if (ch_code !== 8'b0011_0000) begin
         errs++;
         $display("FAIL debounce_chcode: got %b want 00110000", ch_code);
      end
   endtask

   task automatic test_reversal;
      logic [7:0] pr [6];
      logic [1:0] ec [6];
      logic       eg [6];
      pr = '{8'd110, 8'd110, 8'd90, 8'd90, 8'd90, 8'd100};
      ec = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
      eg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_cfg(8'd105, 8'd95);
      for (int k = 0; k < 6; k++) begin
         send(1, pr[k]);
         vecs++;
         if (res_valid !== 1'b1 || res_ch !== 2'd1 || res_code !== ec[k] ||
             res_changed !== eg[k]) begin
            errs++;
            $display("FAIL reversal[%0d]: got v=%b ch=%0d code=%b chg=%b want v=1 ch=1 code=%b chg=%b",
                     k, res_valid, res_ch, res_code, res_changed, ec[k], eg[k]);
         end
      end
   endtask

   task automatic test_config_priority;
      req_valid = 4'b1001;
      req_price[7:0]   = 8'd110;
      req_price[31:24] = 8'd110;
      cfg_valid = 1'b1;
      cfg_upper = 8'd120;
      cfg_lower = 8'd80;
      #1;
      vecs++;
      if (req_ready !== 4'b0000) begin
         errs++;
         $display("FAIL cfgprio_ready: got %b want 0000", req_ready);
      end
      @(posedge clk); #2;
      cfg_valid = 1'b0;
      req_valid = 4'b0001;
      vecs++;
      if (res_valid !== 1'b0 || ch_code !== 8'h00 || cfg_err !== 1'b0) begin
         errs++;
         $display("FAIL cfgprio_clear: got v=%b cc=%h err=%b want v=0 cc=00 err=0",
                  res_valid, ch_code, cfg_err);
      end
      #1;
      vecs++;
      if (req_ready !== 4'b0001) begin
         errs++;
         $display("FAIL cfgprio_grant: got %b want 0001", req_ready);
      end
      @(posedge clk); #2;
      req_valid = '0;
      vecs++;
      if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_code !== 2'b01 ||
          res_changed !== 1'b1 || ch_code !== 8'h01) begin
         errs++;
         $display("FAIL cfgprio_inside: got v=%b ch=%0d code=%b chg=%b cc=%h want v=1 ch=0 code=01 chg=1 cc=01",
                  res_valid, res_ch, res_code, res_changed, ch_code);
      end
   endtask

   task automatic test_invalid_config;
      do_cfg(8'd105, 8'd95);
      send(3, 8'd110);
      vecs++;
      if (res_valid !== 1'b1 || res_code !== 2'b00) begin
         errs++;
         $display("FAIL badcfg_pre: got v=%b code=%b want v=1 code=00", res_valid, res_code);
      end
      req_valid = 4'b1000;
      cfg_valid = 1'b1;
      cfg_upper = 8'd50;
      cfg_lower = 8'd60;
      #1;
      vecs++;
      if (req_ready !== 4'b0000) begin
         errs++;
         $display("FAIL badcfg_ready: got %b want 0000", req_ready);
      end
      @(posedge clk); #2;
      cfg_valid = 1'b0;
      req_valid = '0;
      vecs++;
      if (cfg_err !== 1'b1 || res_valid !== 1'b0) begin
         errs++;
         $display("FAIL badcfg_err: got err=%b v=%b want err=1 v=0", cfg_err, res_valid);
      end
      @(posedge clk); #2;
      vecs++;
      if (cfg_err !== 1'b0) begin
         errs++;
         $display("FAIL badcfg_pulse: got err=%b want 0", cfg_err);
      end
      send(3, 8'd110);
      vecs++;
      if (res_code !== 2'b00 || res_changed !== 1'b0) begin
         errs++;
         $display("FAIL badcfg_ctx2: got code=%b chg=%b want code=00 chg=0", res_code, res_changed);
      end
      send(3, 8'd110);
      vecs++;
      if (res_code !== 2'b11 || res_changed !== 1'b1) begin
         errs++;
         $display("FAIL badcfg_ctx3: got code=%b chg=%b want code=11 chg=1", res_code, res_changed);
      end
      send(0, 8'd104);
      vecs++;
      if (res_ch !== 2'd0 || res_code !== 2'b01 || res_changed !== 1'b1) begin
         errs++;
         $display("FAIL badcfg_thr: got ch=%0d code=%b chg=%b want ch=0 code=01 chg=1",
                  res_ch, res_code, res_changed);
      end
   endtask

   task automatic test_equal_thresholds;
      logic [7:0] pr [4];
      logic [1:0] ec [4];
      logic       eg [4];
      pr = '{8'd100, 8'd100, 8'd100, 8'd99};
      ec = '{2'b00, 2'b00, 2'b11, 2'b11};
      eg = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_cfg(8'd100, 8'd100);
      for (int k = 0; k < 4; k++) begin
         send(2, pr[k]);
         vecs++;
         if (res_valid !== 1'b1 || res_code !== ec[k] || res_changed !== eg[k]) begin
            errs++;
            $display("FAIL equal[%0d]: got v=%b code=%b chg=%b want v=1 code=%b chg=%b",
                     k, res_valid, res_code, res_changed, ec[k], eg[k]);
         end
      end
   endtask

   task automatic test_reset_midstream;
      logic [1:0] ec [3];
      ec = '{2'b00, 2'b00, 2'b11};
      send(1, 8'd110);
      send(1, 8'd110);
      reset = 1'b1;
      req_valid = 4'b0010;
      #1;
      vecs++;
      if (req_ready !== 4'b0000) begin
         errs++;
         $display("FAIL rst_mid_ready: got %b want 0000", req_ready);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      vecs++;
      if (res_valid !== 1'b0 || ch_code !== 8'h00 || res_ch !== 2'd0 || res_code !== 2'b00) begin
         errs++;
         $display("FAIL rst_mid_outs: got v=%b cc=%h ch=%0d code=%b want v=0 cc=00 ch=0 code=00",
                  res_valid, ch_code, res_ch, res_code);
      end
      req_valid = 4'b0011;
      req_price[7:0]  = 8'd100;
      req_price[15:8] = 8'd110;
      #1;
      vecs++;
      if (req_ready !== 4'b0001) begin
         errs++;
         $display("FAIL rst_mid_rrptr: got %b want 0001", req_ready);
      end
      @(posedge clk); #2;
      req_valid = '0;
      vecs++;
      if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_code !== 2'b01) begin
         errs++;
         $display("FAIL rst_mid_thr: got v=%b ch=%0d code=%b want v=1 ch=0 code=01",
                  res_valid, res_ch, res_code);
      end
      for (int k = 0; k < 3; k++) begin
         send(1, 8'd110);
         vecs++;
         if (res_valid !== 1'b1 || res_ch !== 2'd1 || res_code !== ec[k]) begin
            errs++;
            $display("FAIL rst_mid_rise[%0d]: got v=%b ch=%0d code=%b want v=1 ch=1 code=%b",
                     k, res_valid, res_ch, res_code, ec[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_debounce();
      test_reversal();
      test_config_priority();
      test_invalid_config();
      test_equal_thresholds();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
